or_node_seq: RTL

- Per-node step sequencer for the replica-exchange salesman engine.
- Issues the ordered phase pulses that drive one replica node: random, delta distance, metropolis, replica test, ordering exchange.
- Generalises the fixed single-mode step into three features:
  - a configurable iteration count;
  - a programmable replica-exchange interval with even/odd pair alternation;
  - round-robin over a mask of opt modes.

---
 rtl/or_node_seq_if.sv | 47 ++++
 rtl/or_node_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/or_node_seq_if.sv
// rtl/or_node_seq_if.sv - control/status bundle between a replica-node sequencer and its driver
//
// Purpose: groups the run-control inputs and the phase-pulse/status outputs of
// or_node_seq so the sequencer and its controller connect through one port.
// Signals:
//   start, abort              run control (driver -> sequencer)
//   iter_num, ex_interval     iteration count and replica-test interval
//   mode_mask                 enabled opt modes
//   opt_mode                  opt mode of the current iteration
//   random_run .. exchange_run  one-cycle phase pulses
//   exchange_bank             pair parity for the current replica test
//   busy, done, iter_cnt      run status
// Modports: master = driver side, slave = sequencer side.

interface or_node_seq_if #(
  parameter int MODE_NUM = 2,
  parameter int ITER_W   = 16,
  parameter int MODE_W   = (MODE_NUM > 1) ? $clog2(MODE_NUM) : 1
);
  logic                start;
  logic                abort;
  logic [ITER_W-1:0]   iter_num;
  logic [ITER_W-1:0]   ex_interval;
  logic [MODE_NUM-1:0] mode_mask;
  logic [MODE_W-1:0]   opt_mode;
  logic                random_run;
  logic                distance_run;
  logic                metropolis_run;
  logic                replica_run;
  logic                exchange_run;
  logic                exchange_bank;
  logic                busy;
  logic                done;
  logic [ITER_W-1:0]   iter_cnt;

  modport master (
    output start, abort, iter_num, ex_interval, mode_mask,
    input  opt_mode, random_run, distance_run, metropolis_run, replica_run,
           exchange_run, exchange_bank, busy, done, iter_cnt
  );

  modport slave (
    input  start, abort, iter_num, ex_interval, mode_mask,
    output opt_mode, random_run, distance_run, metropolis_run, replica_run,
           exchange_run, exchange_bank, busy, done, iter_cnt
  );
endinterface

// File: rtl/or_node_seq.sv
// rtl/or_node_seq.sv - per-node step sequencer for the replica-exchange salesman engine
//
// Purpose: issues the ordered phase pulses (random, distance, metropolis,
// optional replica test, ordering exchange) for one replica node, for a
// configurable number of iterations, with periodic replica tests alternating
// even/odd pairs and round-robin over the enabled opt modes.
// Ports:
//   clk    clock
//   reset  synchronous active-high reset
//   bus    or_node_seq_if.slave: start/abort/iter_num/ex_interval/mode_mask in;
//          opt_mode, phase pulses, exchange_bank, busy, done, iter_cnt out.
// All outputs are registered.

module or_node_seq #(
  parameter int MODE_NUM = 2,
  parameter int ITER_W   = 16,
  parameter int DIST_LAT = 4,
  parameter int MTR_LAT  = 2,
  parameter int REP_LAT  = 3,
  parameter int EX_LAT   = 32
) (
  input logic         clk,
  input logic         reset,
  or_node_seq_if.slave bus
);

  localparam int MODE_W  = (MODE_NUM > 1) ? $clog2(MODE_NUM) : 1;
  localparam int MAX_A   = (DIST_LAT > MTR_LAT) ? DIST_LAT : MTR_LAT;
  localparam int MAX_B   = (REP_LAT > EX_LAT) ? REP_LAT : EX_LAT;
  localparam int MAX_LAT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int LAT_W   = $clog2(MAX_LAT + 1);

  // Last cycle index of each timed state (latency counter starts at 0).
  localparam logic [LAT_W-1:0] DIST_END = LAT_W'(DIST_LAT - 1);
  localparam logic [LAT_W-1:0] MTR_END  = LAT_W'(MTR_LAT - 1);
  localparam logic [LAT_W-1:0] REP_END  = LAT_W'(REP_LAT - 1);
  localparam logic [LAT_W-1:0] EX_END   = LAT_W'(EX_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAND,
    S_DIST,
    S_MTR,
    S_REP,
    S_EXCH,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [LAT_W-1:0]    r_lat;
  logic [ITER_W-1:0]   r_iter_num;
  logic [ITER_W-1:0]   r_int_cnt;
  logic                r_parity;
  logic [MODE_W-1:0]   r_opt_mode;
  logic                r_random_run;
  logic                r_distance_run;
  logic                r_metropolis_run;
  logic                r_replica_run;
  logic                r_exchange_run;
  logic                r_exchange_bank;
  logic                r_busy;
  logic                r_done;
  logic [ITER_W-1:0]   r_iter_cnt;

  logic [ITER_W:0]     w_iter_inc;
  logic                w_last_iter;
  logic [ITER_W-1:0]   w_int_inc;
  logic                w_rep_due;

  // One extra bit so the last-iteration compare and saturation see the carry.
  assign w_iter_inc  = {1'b0, r_iter_cnt} + {{ITER_W{1'b0}}, 1'b1};
  assign w_last_iter = (w_iter_inc == {1'b0, r_iter_num});
  assign w_int_inc   = r_int_cnt + ITER_W'(1);
  assign w_rep_due   = (bus.ex_interval != '0) && (w_int_inc == bus.ex_interval);

  function automatic logic [MODE_W-1:0] f_lowest(input logic [MODE_NUM-1:0] m);
    f_lowest = '0;
    for (int i = MODE_NUM - 1; i >= 0; i--) begin
      if (m[i]) f_lowest = MODE_W'(i);
    end
  endfunction

  // Next enabled mode above cur, wrapping to the lowest; holds on an empty mask.
  function automatic logic [MODE_W-1:0] f_next(input logic [MODE_NUM-1:0] m,
                                               input logic [MODE_W-1:0]   cur);
    logic found;
    f_next = cur;
    found  = 1'b0;
    for (int i = 0; i < MODE_NUM; i++) begin
      if (!found && m[i] && (i > int'(cur))) begin
        f_next = MODE_W'(i);
        found  = 1'b1;
      end
    end
    if (!found && (m != '0)) f_next = f_lowest(m);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_lat            <= '0;
      r_iter_num       <= '0;
      r_int_cnt        <= '0;
      r_parity         <= 1'b0;
      r_opt_mode       <= '0;
      r_random_run     <= 1'b0;
      r_distance_run   <= 1'b0;
      r_metropolis_run <= 1'b0;
      r_replica_run    <= 1'b0;
      r_exchange_run   <= 1'b0;
      r_exchange_bank  <= 1'b0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_iter_cnt       <= '0;
    end else begin
      // Pulses are raised on the edge that enters their state, so each one
      // is high exactly during that state's first cycle.
      r_random_run     <= 1'b0;
      r_distance_run   <= 1'b0;
      r_metropolis_run <= 1'b0;
      r_replica_run    <= 1'b0;
      r_exchange_run   <= 1'b0;
      r_done           <= 1'b0;

      if (bus.abort) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              if ((bus.iter_num != '0) && (bus.mode_mask != '0)) begin
                r_state      <= S_RAND;
                r_random_run <= 1'b1;
                r_busy       <= 1'b1;
                r_iter_cnt   <= '0;
                r_int_cnt    <= '0;
                r_iter_num   <= bus.iter_num;
                r_opt_mode   <= f_lowest(bus.mode_mask);
              end else begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
            end
          end

          S_RAND: begin
            r_state        <= S_DIST;
            r_distance_run <= 1'b1;
            r_lat          <= '0;
          end

          S_DIST: begin
            if (r_lat == DIST_END) begin
              r_state          <= S_MTR;
              r_metropolis_run <= 1'b1;
              r_lat            <= '0;
            end else begin
              r_lat <= r_lat + LAT_W'(1);
            end
          end

          S_MTR: begin
            if (r_lat == MTR_END) begin
              r_lat <= '0;
              if (w_rep_due) begin
                r_state         <= S_REP;
                r_replica_run   <= 1'b1;
                r_int_cnt       <= '0;
                // Bank is captured here so it stays stable through the EXCH
                // that follows, even though the parity flips at REP exit.
                r_exchange_bank <= r_parity;
              end else begin
                r_state        <= S_EXCH;
                r_exchange_run <= 1'b1;
                r_int_cnt      <= w_int_inc;
              end
            end else begin
              r_lat <= r_lat + LAT_W'(1);
            end
          end

          S_REP: begin
            if (r_lat == REP_END) begin
              r_state        <= S_EXCH;
              r_exchange_run <= 1'b1;
              r_parity       <= ~r_parity;
              r_lat          <= '0;
            end else begin
              r_lat <= r_lat + LAT_W'(1);
            end
          end

          S_EXCH: begin
            if (r_lat == EX_END) begin
              r_lat      <= '0;
              r_iter_cnt <= w_iter_inc[ITER_W] ? r_iter_cnt : w_iter_inc[ITER_W-1:0];
              r_opt_mode <= f_next(bus.mode_mask, r_opt_mode);
              if (w_last_iter) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
              end else begin
                r_state      <= S_RAND;
                r_random_run <= 1'b1;
              end
            end else begin
              r_lat <= r_lat + LAT_W'(1);
            end
          end

          S_DONE: begin
            r_state <= S_IDLE;
          end

          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.opt_mode       = r_opt_mode;
  assign bus.random_run     = r_random_run;
  assign bus.distance_run   = r_distance_run;
  assign bus.metropolis_run = r_metropolis_run;
  assign bus.replica_run    = r_replica_run;
  assign bus.exchange_run   = r_exchange_run;
  assign bus.exchange_bank  = r_exchange_bank;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.iter_cnt       = r_iter_cnt;

endmodule
